// File: rtl/ibex_ibus_arbiter.sv
// Two-port instruction-bus arbiter: one port to the instruction memory, in-order response routing.
// Build option: define IBEX_IBUS_ARB_FIXED_PRIO_EN so port 0 always wins; otherwise round-robin.
module ibex_ibus_arbiter #(
    parameter int unsigned NumOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_req_i,
    input  logic [31:0] p0_addr_i,
    output logic        p0_gnt_o,
    output logic        p0_rvalid_o,
    input  logic        p1_req_i,
    input  logic [31:0] p1_addr_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    output logic        proto_err_o
);

    localparam int unsigned CntW = $clog2(NumOutstanding + 1);
    localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

    logic [CntW-1:0]           count_q, count_d;
    logic [NumOutstanding-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic                      lock_q, lock_d;
    logic                      lock_owner_q, lock_owner_d;
    logic [31:0]               lock_addr_q, lock_addr_d;
    logic                      proto_err_q, proto_err_d;

    logic arb_en, winner, owner, push, pop, head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(NumOutstanding - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

`ifdef IBEX_IBUS_ARB_FIXED_PRIO_EN
    assign winner = ~p0_req_i;
`else
    logic rr_q, rr_d;

    // rr_q names the port favoured in a contested cycle; it flips away from each granted port.
    always_comb begin
        winner = (p0_req_i & p1_req_i) ? rr_q : ~p0_req_i;
        rr_d   = push ? ~owner : rr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        arb_en       = ~rst_i & ~lock_q & (count_q < CntW'(NumOutstanding));
        instr_req_o  = lock_q | (arb_en & (p0_req_i | p1_req_i));
        owner        = lock_q ? lock_owner_q : winner;
        instr_addr_o = '0;
        if (instr_req_o) begin
            instr_addr_o = lock_q ? lock_addr_q : (owner ? p1_addr_i : p0_addr_i);
        end
        push        = instr_req_o & instr_gnt_i;
        p0_gnt_o    = push & ~owner;
        p1_gnt_o    = push & owner;
        pop         = instr_rvalid_i & (count_q != '0);
        head        = fifo_q[rptr_q];
        p0_rvalid_o = pop & ~head;
        p1_rvalid_o = pop & head;
        rdata_o     = rst_i ? 32'h0 : instr_rdata_i;
        err_o       = ~rst_i & instr_err_i;
        busy_o      = (count_q != '0) | instr_req_o;
        proto_err_o = proto_err_q;
    end

    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        lock_addr_d  = lock_addr_q;
        fifo_d       = fifo_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        proto_err_d  = proto_err_q | (instr_rvalid_i & (count_q == '0));

        // An issued but ungranted request is frozen until the bus accepts it.
        if (instr_req_o & ~instr_gnt_i & ~lock_q) begin
            lock_d       = 1'b1;
            lock_owner_d = owner;
            lock_addr_d  = instr_addr_o;
        end else if (push) begin
            lock_d = 1'b0;
        end

        if (push) begin
            fifo_d[wptr_q] = owner;
            wptr_d         = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q      <= '0;
            fifo_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_addr_q  <= 32'h0;
            proto_err_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            fifo_q       <= fifo_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            lock_addr_q  <= lock_addr_d;
            proto_err_q  <= proto_err_d;
        end
    end

endmodule
